// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port: memory loads win
// contention, but the ALU is forced through after STARVE_LIMIT consecutive losses.
module regfile_wb_arbiter #(
   parameter int STARVE_LIMIT = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alu_valid,
   input  logic [4:0]       alu_wreg,
   input  logic [31:0]      alu_wdata,
   output logic             alu_ready,
   input  logic             mem_valid,
   input  logic [4:0]       mem_wreg,
   input  logic [31:0]      mem_wdata,
   output logic             mem_ready,
   output logic             regwrite,
   output logic [4:0]       wreg,
   output logic [31:0]      wdata,
   output logic [CNT_W-1:0] conflicts
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]  streak;
   logic        both;
   logic        force_alu;
   logic        alu_xfer;
   logic        mem_xfer;
   logic [4:0]  sel_wreg;
   logic [31:0] sel_wdata;

   assign both      = alu_valid & mem_valid;
   assign force_alu = (streak == LIMIT);

   // Readies depend only on the valids and streak; held low throughout reset.
   assign alu_ready = reset & alu_valid & (~mem_valid | force_alu);
   assign mem_ready = reset & mem_valid & (~alu_valid | ~force_alu);

   assign alu_xfer  = alu_valid & alu_ready;
   assign mem_xfer  = mem_valid & mem_ready;
   assign sel_wreg  = mem_xfer ? mem_wreg  : alu_wreg;
   assign sel_wdata = mem_xfer ? mem_wdata : alu_wdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regwrite  <= 1'b0;
         wreg      <= '0;
         wdata     <= '0;
         streak    <= '0;
         conflicts <= '0;
      end else begin
         if (both)
            conflicts <= conflicts + CNT_W'(1);

         if (alu_xfer)
            streak <= '0;
         else if (mem_xfer && both)
            streak <= streak + 4'd1;

         // Writes to r0 are acknowledged but never reach the register file.
         regwrite <= 1'b0;
         if ((alu_xfer || mem_xfer) && (sel_wreg != 5'd0)) begin
            regwrite <= 1'b1;
            wreg     <= sel_wreg;
            wdata    <= sel_wdata;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; small CNT_W so the wrap is reachable.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, mem_valid;
   logic [4:0]  alu_wreg, mem_wreg;
   logic [31:0] alu_wdata, mem_wdata;
   logic        alu_ready, mem_ready;
   logic        regwrite;
   logic [4:0]  wreg;
   logic [31:0] wdata;
   logic [3:0]  conflicts;

   int n_total = 0;
   int n_pass  = 0;

   regfile_wb_arbiter #(.STARVE_LIMIT(3), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_wreg(alu_wreg), .alu_wdata(alu_wdata), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .regwrite(regwrite), .wreg(wreg), .wdata(wdata), .conflicts(conflicts)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      // power-up state
      n_total++;
      if ({regwrite, wreg, wdata, conflicts} !== '0)
         $display("FAIL por_outputs: got rw=%0b wreg=%0d wdata=%0h cnf=%0d want all 0", regwrite, wreg, wdata, conflicts);
      else n_pass++;
      reset = 1'b1;
      tick();
      // put a write in flight, then yank reset mid-pulse
      alu_valid = 1'b1; alu_wreg = 5'd1; alu_wdata = 32'd14;
      tick();
      alu_valid = 1'b0;
      n_total++;
      if (regwrite !== 1'b1 || wreg !== 5'd1 || wdata !== 32'd14)
         $display("FAIL reset_setup: got rw=%0b wreg=%0d wdata=%0d want 1/1/14", regwrite, wreg, wdata);
      else n_pass++;
      alu_valid = 1'b1; mem_valid = 1'b1; mem_wreg = 5'd2; mem_wdata = 32'd7;
      #2 reset = 1'b0;
      #1;
      n_total++;
      if (regwrite !== 1'b0 || wreg !== 5'd0 || wdata !== 32'd0)
         $display("FAIL reset_async_outputs: got rw=%0b wreg=%0d wdata=%0h want 0", regwrite, wreg, wdata);
      else n_pass++;
      n_total++;
      if (alu_ready !== 1'b0 || mem_ready !== 1'b0)
         $display("FAIL reset_readies: got alu=%0b mem=%0b want 0/0", alu_ready, mem_ready);
      else n_pass++;
      n_total++;
      if (conflicts !== 4'd0)
         $display("FAIL reset_conflicts: got %0d want 0", conflicts);
      else n_pass++;
      tick();
      n_total++;
      if (regwrite !== 1'b0 || conflicts !== 4'd0)
         $display("FAIL reset_held: got rw=%0b cnf=%0d want 0/0", regwrite, conflicts);
      else n_pass++;
      alu_valid = 1'b0; mem_valid = 1'b0;
      reset = 1'b1;
      tick();
      n_total++;
      if (regwrite !== 1'b0)
         $display("FAIL reset_release_idle: got rw=%0b want 0", regwrite);
      else n_pass++;
   endtask

   task automatic test_single_alu;
      alu_valid = 1'b1; alu_wreg = 5'd1; alu_wdata = 32'd14;
      #1;
      n_total++;
      if (alu_ready !== 1'b1 || mem_ready !== 1'b0)
         $display("FAIL single_ready: got alu=%0b mem=%0b want 1/0", alu_ready, mem_ready);
      else n_pass++;
      tick();
      alu_valid = 1'b0;
      n_total++;
      if (regwrite !== 1'b1 || wreg !== 5'd1 || wdata !== 32'd14)
         $display("FAIL single_write: got rw=%0b wreg=%0d wdata=%0d want 1/1/14", regwrite, wreg, wdata);
      else n_pass++;
      #1;
      n_total++;
      if (alu_ready !== 1'b0 || mem_ready !== 1'b0)
         $display("FAIL idle_readies: got alu=%0b mem=%0b want 0/0", alu_ready, mem_ready);
      else n_pass++;
      tick();
      n_total++;
      if (regwrite !== 1'b0)
         $display("FAIL single_pulse_end: got rw=%0b want 0", regwrite);
      else n_pass++;
   endtask

   task automatic test_reg_zero;
      alu_valid = 1'b1; alu_wreg = 5'd3; alu_wdata = 32'h55;
      tick();
      alu_valid = 1'b0;
      mem_valid = 1'b1; mem_wreg = 5'd0; mem_wdata = 32'hDEADBEEF;
      #1;
      n_total++;
      if (mem_ready !== 1'b1)
         $display("FAIL zero_ready: got mem_ready=%0b want 1", mem_ready);
      else n_pass++;
      tick();
      mem_valid = 1'b0;
      n_total++;
      if (regwrite !== 1'b0 || wreg !== 5'd3 || wdata !== 32'h55)
         $display("FAIL zero_drop: got rw=%0b wreg=%0d wdata=%0h want 0/3/55", regwrite, wreg, wdata);
      else n_pass++;
      tick();
      n_total++;
      if (regwrite !== 1'b0 || wreg !== 5'd3 || wdata !== 32'h55)
         $display("FAIL zero_hold: got rw=%0b wreg=%0d wdata=%0h want 0/3/55", regwrite, wreg, wdata);
      else n_pass++;
   endtask

   task automatic test_contention;
      logic [4:0]  exp_alu_grant;
      logic [4:0]  exp_wreg [5];
      logic [31:0] exp_wdata [5];
      logic [3:0]  exp_cnf;
      exp_alu_grant = 5'b01000;
      exp_wreg  = '{5'd2, 5'd2, 5'd2, 5'd5, 5'd2};
      exp_wdata = '{32'd1, 32'd2, 32'd3, 32'hAA, 32'd4};
      exp_cnf   = conflicts;
      alu_valid = 1'b1; alu_wreg = 5'd5; alu_wdata = 32'hAA;
      mem_valid = 1'b1; mem_wreg = 5'd2; mem_wdata = 32'd1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_total++;
         if (alu_ready !== exp_alu_grant[i] || mem_ready !== ~exp_alu_grant[i])
            $display("FAIL contend_grant[%0d]: got alu=%0b mem=%0b want alu=%0b", i, alu_ready, mem_ready, exp_alu_grant[i]);
         else n_pass++;
         tick();
         exp_cnf = exp_cnf + 4'd1;
         if (!exp_alu_grant[i]) mem_wdata = mem_wdata + 32'd1;
         n_total++;
         if (regwrite !== 1'b1 || wreg !== exp_wreg[i] || wdata !== exp_wdata[i])
            $display("FAIL contend_out[%0d]: got rw=%0b wreg=%0d wdata=%0h want 1/%0d/%0h", i, regwrite, wreg, wdata, exp_wreg[i], exp_wdata[i]);
         else n_pass++;
         n_total++;
         if (conflicts !== exp_cnf)
            $display("FAIL contend_cnf[%0d]: got %0d want %0d", i, conflicts, exp_cnf);
         else n_pass++;
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1; alu_wreg = 5'(i + 1); alu_wdata = 32'(10 + i);
         #1;
         n_total++;
         if (alu_ready !== 1'b1)
            $display("FAIL b2b_ready[%0d]: got %0b want 1", i, alu_ready);
         else n_pass++;
         tick();
         n_total++;
         if (regwrite !== 1'b1 || wreg !== 5'(i + 1) || wdata !== 32'(10 + i))
            $display("FAIL b2b_out[%0d]: got rw=%0b wreg=%0d wdata=%0d want 1/%0d/%0d", i, regwrite, wreg, wdata, i + 1, 10 + i);
         else n_pass++;
      end
      alu_valid = 1'b0;
      tick();
      n_total++;
      if (regwrite !== 1'b0 || wreg !== 5'd4 || wdata !== 32'd13)
         $display("FAIL b2b_end: got rw=%0b wreg=%0d wdata=%0d want 0/4/13", regwrite, wreg, wdata);
      else n_pass++;
   endtask

   task automatic test_wrap;
      int exp_seq [17];
      for (int i = 0; i < 15; i++) exp_seq[i] = i + 1;
      exp_seq[15] = 0;
      exp_seq[16] = 1;
      #1 reset = 1'b0;
      #1 reset = 1'b1;
      alu_valid = 1'b1; alu_wreg = 5'd6; alu_wdata = 32'h1;
      mem_valid = 1'b1; mem_wreg = 5'd7; mem_wdata = 32'h2;
      for (int i = 0; i < 17; i++) begin
         tick();
         n_total++;
         if (conflicts !== 4'(exp_seq[i]))
            $display("FAIL wrap_cnf[%0d]: got %0d want %0d", i, conflicts, exp_seq[i]);
         else n_pass++;
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      tick();
      n_total++;
      if (conflicts !== 4'd1)
         $display("FAIL wrap_hold: got %0d want 1", conflicts);
      else n_pass++;
   endtask

   initial begin
      reset = 1'b0;
      alu_valid = 1'b0; alu_wreg = '0; alu_wdata = '0;
      mem_valid = 1'b0; mem_wreg = '0; mem_wdata = '0;
      repeat (2) tick();
      test_reset();
      test_single_alu();
      test_reg_zero();
      test_contention();
      test_back_to_back();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port between the two pipeline writeback sources: ALU results and memory load data. It arbitrates between the two valid/ready requesters, with memory priority and a bounded starvation guard for the ALU. Each accepted write is registered, then presented to the register file as a one-cycle `regwrite`/`wreg`/`wdata` pulse. Writes targeting register 0 are accepted but never forwarded.

## Interface
- `STARVE_LIMIT`, default 3: maximum consecutive contested mem grants before the ALU is forced through (legal range 1..15).
- `CNT_W`, default 16: width of the conflict counter.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `alu_valid`  in  1  ALU writeback request.
- `alu_wreg`  in  5  ALU destination register.
- `alu_wdata`  in  32  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle (combinational).
- `mem_valid`  in  1  load writeback request.
- `mem_wreg`  in  5  load destination register.
- `mem_wdata`  in  32  load data.
- `mem_ready`  out  1  load request accepted this cycle (combinational).
- `regwrite`  out  1  register-file write enable (registered).
- `wreg`  out  5  register-file write address (registered).
- `wdata`  out  32  register-file write data (registered).
- `conflicts`  out  CNT_W  count of cycles with both requests valid; wraps.

## Operation
- **Handshake:**
  - A transfer occurs on a rising edge when `X_valid && X_ready`.
  - Requesters hold valid, wreg and wdata stable until accepted.
  - At most one ready is high per cycle.
  - The arbiter never stalls when only one requester is valid.
- **Grant rules:**
  - Only `alu_valid`: `alu_ready=1`.
  - Only `mem_valid`: `mem_ready=1`.
  - Both valid and `streak < STARVE_LIMIT`: `mem_ready=1`.
  - Both valid and `streak == STARVE_LIMIT`: `alu_ready=1`.
  - Neither valid: both readies 0.
- **Streak counter** (4 bits):
  - Increments on a contested mem grant (both valid, mem granted).
  - Clears on any ALU grant.
  - Holds otherwise.
  - Never exceeds `STARVE_LIMIT`.
- **Conflict counter:** increments by 1 every cycle in which both valids are high; wraps from all-ones to 0.
- **Output register:**
  - On a transfer with `wreg != 0`: next cycle `regwrite=1`, and `wreg`/`wdata` take the granted requester's values.
  - On a transfer with `wreg == 0`: the request is acknowledged and `regwrite` stays 0.
  - With no transfer: `regwrite=0`; `wreg`/`wdata` hold their last values.
- **Reset (`reset=0`):**
  - `regwrite=0`, `wreg=0`, `wdata=0`, `streak=0`, `conflicts=0`.
  - `alu_ready` and `mem_ready` are forced to 0 while reset is low.
  - A write captured but not yet presented is discarded; no regfile write occurs for it.

## Timing
- Latency is 1 cycle: a transfer at edge N produces `regwrite=1` during cycle N..N+1, so the register file commits at edge N+1.
- Throughput is one write per cycle; back-to-back grants give a continuous `regwrite=1`.
- Ready depends combinationally only on the valids and `streak`, never on wreg or wdata.
- Reset assertion takes effect asynchronously.
- Deassertion is sampled at the next rising edge; the first grant is possible on the first edge after `reset` returns to 1.
- The `regwrite` pulse lasts exactly one cycle per accepted nonzero write.

## Test plan
- **Reset:**
  - Drive `reset=0` mid-pulse, with `regwrite=1`, `wreg=1`, `wdata=14`.
  - Required: all outputs read 0 immediately, both readies are 0, and `conflicts=0`.
- **Single ALU write:**
  - `alu_valid=1`, `alu_wreg=1`, `alu_wdata=14` for one cycle.
  - Required: `alu_ready=1` that cycle; the next cycle shows `regwrite=1`, `wreg=1`, `wdata=14`; the following cycle shows `regwrite=0`.
- **Register-zero drop:**
  - `mem_valid=1`, `mem_wreg=0`, `mem_wdata=0xDEADBEEF`.
  - Required: `mem_ready=1`; `regwrite` stays 0; `wreg`/`wdata` unchanged.
- **Contention with starvation guard** (`STARVE_LIMIT=3`):
  - Hold both valid; mem writes r2 with values 1, 2, 3, 4…; ALU writes r5 with 0xAA.
  - Required: grant order mem, mem, mem, alu, mem.
  - Required outputs: `wreg` 2, 2, 2, 5, 2 with `wdata` 1, 2, 3, 0xAA, 4.
  - Required: `conflicts` increments by 1 each contested cycle.
- **Back-to-back throughput:**
  - ALU only, 4 consecutive writes to r1..r4 with data 10..13.
  - Required: `regwrite=1` for 4 consecutive cycles, with `wreg` 1..4 and `wdata` 10..13.
- **Counter wrap** (`CNT_W=4`):
  - 17 contested cycles.
  - Required: `conflicts` reads 15 then 0, then 1.
